// File: rtl/dds_sweep_scheduler_if.sv
// Load and DDS handshake bundle for dds_sweep_scheduler.
// master = scheduler side, slave = serial reader / DDS serializer side.
interface dds_sweep_scheduler_if #(
  parameter int WORD_W = 184
);
  logic              load_valid;
  logic              load_ready;
  logic [0:WORD_W-1] load_word;
  logic              dds_valid;
  logic              dds_ready;
  logic [0:WORD_W-1] dds_word;

  modport master (
    input  load_valid, load_word, dds_ready,
    output load_ready, dds_valid, dds_word
  );
  modport slave (
    output load_valid, load_word, dds_ready,
    input  load_ready, dds_valid, dds_word
  );
endinterface

// File: rtl/dds_sweep_scheduler.sv
// Stores DDS profile words in IDLE and issues them one per trigger after arm.
// Optional `DDS_SWEEP_LOOP_EN: wrap to slot 0 forever and count wraps in loop_count.
module dds_sweep_scheduler #(
  parameter int DEPTH  = 20,
  parameter int WORD_W = 184,
  parameter int CNT_W  = 5
) (
  input  logic                   ten_MHz_ext,
  input  logic                   rst,
  dds_sweep_scheduler_if.master  bus,
  input  logic                   arm,
  input  logic                   trigger,
  input  logic                   abort,
  output logic [CNT_W-1:0]       sweep_total,
  output logic [CNT_W-1:0]       sweep_index,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   missed_trig
`ifdef DDS_SWEEP_LOOP_EN
  ,
  output logic [7:0]             loop_count
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_TRIG = 2'd2,
    DONE      = 2'd3
  } state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  wr_ptr, rd_ptr;
  logic [0:WORD_W-1] mem [DEPTH];
  logic [0:WORD_W-1] word_q;
  logic              full, hs, last, arm_ok, load_ok;

  assign full    = (wr_ptr == CNT_W'(DEPTH));
  assign hs      = (state == ISSUE) && bus.dds_ready;
  assign last    = (rd_ptr == wr_ptr - CNT_W'(1));
  assign arm_ok  = (state == IDLE) && arm && (wr_ptr != '0);
  assign load_ok = (state == IDLE) && bus.load_valid && !full;

  // state register
  always_ff @(posedge ten_MHz_ext) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // next-state logic; abort wins over everything else
  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:      if (arm_ok) state_nxt = ISSUE;
`ifdef DDS_SWEEP_LOOP_EN
        ISSUE:     if (hs) state_nxt = WAIT_TRIG;
`else
        ISSUE:     if (hs) state_nxt = last ? DONE : WAIT_TRIG;
`endif
        WAIT_TRIG: if (trigger) state_nxt = ISSUE;
        DONE:      state_nxt = DONE;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  // state-decoded outputs
  always_comb begin
    bus.load_ready = (state == IDLE) && !full;
    bus.dds_valid  = (state == ISSUE);
    busy           = (state == ISSUE) || (state == WAIT_TRIG);
    done           = (state == DONE);
  end

  assign bus.dds_word = word_q;
  assign sweep_total  = wr_ptr;

  always_ff @(posedge ten_MHz_ext) begin
    if (load_ok && !abort) mem[wr_ptr] <= bus.load_word;
  end

  always_ff @(posedge ten_MHz_ext) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      sweep_index <= '0;
      word_q      <= '0;
      overflow    <= 1'b0;
      missed_trig <= 1'b0;
`ifdef DDS_SWEEP_LOOP_EN
      loop_count  <= '0;
`endif
    end else if (abort) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
`ifdef DDS_SWEEP_LOOP_EN
      loop_count  <= '0;
`endif
    end else begin
      if (load_ok) wr_ptr <= wr_ptr + CNT_W'(1);
      if ((state == IDLE) && bus.load_valid && full) overflow <= 1'b1;
      if (arm_ok) begin
        rd_ptr <= '0;
        word_q <= mem[0];
      end
      if ((state == ISSUE) && trigger) missed_trig <= 1'b1;
      if (hs) begin
        sweep_index <= rd_ptr;
        if (!last) begin
          rd_ptr <= rd_ptr + CNT_W'(1);
        end else begin
`ifdef DDS_SWEEP_LOOP_EN
          rd_ptr <= '0;
          if (loop_count != 8'hFF) loop_count <= loop_count + 8'd1;
`endif
        end
      end
      // word is fetched on the trigger so it is registered when dds_valid rises
      if ((state == WAIT_TRIG) && trigger) word_q <= mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_dds_sweep_scheduler.sv
// Directed table-driven bench for dds_sweep_scheduler plus multi-cycle sequences.
module tb_dds_sweep_scheduler;
  localparam int WORD_W = 184;
  localparam int CNT_W  = 5;
`ifdef DDS_SWEEP_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  localparam logic [WORD_W-1:0] WA = {23{8'hA1}};
  localparam logic [WORD_W-1:0] WB = {23{8'hB2}};
  localparam logic [WORD_W-1:0] WC = {23{8'hC3}};
  localparam logic [WORD_W-1:0] WZ = '0;

  logic ten_MHz_ext = 1'b0;
  logic rst, arm, trigger, abort;
  logic [CNT_W-1:0] sweep_total, sweep_index;
  logic busy, done, overflow, missed_trig;
`ifdef DDS_SWEEP_LOOP_EN
  logic [7:0] loop_count;
`endif

  int tests = 0;
  int fails = 0;

  always #50 ten_MHz_ext = ~ten_MHz_ext;

  dds_sweep_scheduler_if #(.WORD_W(WORD_W)) bus ();

  dds_sweep_scheduler dut (
    .ten_MHz_ext (ten_MHz_ext),
    .rst         (rst),
    .bus         (bus),
    .arm         (arm),
    .trigger     (trigger),
    .abort       (abort),
    .sweep_total (sweep_total),
    .sweep_index (sweep_index),
    .busy        (busy),
    .done        (done),
    .overflow    (overflow),
    .missed_trig (missed_trig)
`ifdef DDS_SWEEP_LOOP_EN
    ,
    .loop_count  (loop_count)
`endif
  );

  typedef struct {
    logic rst, lv, arm, trig, abort, dr;
    logic [WORD_W-1:0] w;
    logic dv, lr, busy, done, ovf, miss;
    logic [WORD_W-1:0] dw;
    logic [CNT_W-1:0] total, index;
  } vec_t;

  function automatic vec_t mk(
    input logic r, lv, input logic [WORD_W-1:0] w,
    input logic a, tr, ab, dr,
    input logic dv, input logic [WORD_W-1:0] dw,
    input logic lr, bsy, dn, ov, ms,
    input int tot, idx);
    vec_t v;
    v.rst = r; v.lv = lv; v.w = w; v.arm = a; v.trig = tr; v.abort = ab; v.dr = dr;
    v.dv = dv; v.dw = dw; v.lr = lr; v.busy = bsy; v.done = dn; v.ovf = ov; v.miss = ms;
    v.total = CNT_W'(tot); v.index = CNT_W'(idx);
    return v;
  endfunction

  task automatic chk(input string tag, input string name,
                     input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s.%s got=%0h expected=%0h", tag, name, got, exp);
    end
  endtask

  // drive one cycle of inputs, then check outputs just after the edge
  task automatic apply(input vec_t v, input string tag);
    rst = v.rst; bus.load_valid = v.lv; bus.load_word = v.w;
    arm = v.arm; trigger = v.trig; abort = v.abort; bus.dds_ready = v.dr;
    @(posedge ten_MHz_ext);
    #1;
    chk(tag, "dds_valid",   WORD_W'(bus.dds_valid),  WORD_W'(v.dv));
    if (v.dv || v.rst) chk(tag, "dds_word", bus.dds_word, v.dw);
    chk(tag, "load_ready",  WORD_W'(bus.load_ready), WORD_W'(v.lr));
    chk(tag, "busy",        WORD_W'(busy),           WORD_W'(v.busy));
    chk(tag, "done",        WORD_W'(done),           WORD_W'(v.done));
    chk(tag, "overflow",    WORD_W'(overflow),       WORD_W'(v.ovf));
    chk(tag, "missed_trig", WORD_W'(missed_trig),    WORD_W'(v.miss));
    chk(tag, "sweep_total", WORD_W'(sweep_total),    WORD_W'(v.total));
    chk(tag, "sweep_index", WORD_W'(sweep_index),    WORD_W'(v.index));
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; arm = 1'b0; trigger = 1'b0; abort = 1'b0;
    bus.load_valid = 1'b0; bus.load_word = '0; bus.dds_ready = 1'b0;

    // three-word sweep: reset, load, arm, two triggers, done, abort
    //             r lv w  ar tr ab dr  dv dw lr bsy   dn    ov ms tot idx
    tbl.push_back(mk(1,0,WZ,0,0,0,0,   0,WZ,1,0,    0,    0,0, 0,0));
    tbl.push_back(mk(0,1,WA,0,0,0,0,   0,WZ,1,0,    0,    0,0, 1,0));
    tbl.push_back(mk(0,1,WB,0,0,0,0,   0,WZ,1,0,    0,    0,0, 2,0));
    tbl.push_back(mk(0,1,WC,0,0,0,0,   0,WZ,1,0,    0,    0,0, 3,0));
    tbl.push_back(mk(0,0,WZ,1,0,0,1,   1,WA,0,1,    0,    0,0, 3,0));
    tbl.push_back(mk(0,0,WZ,0,0,0,1,   0,WZ,0,1,    0,    0,0, 3,0));
    tbl.push_back(mk(0,0,WZ,0,1,0,1,   1,WB,0,1,    0,    0,0, 3,0));
    tbl.push_back(mk(0,0,WZ,0,0,0,1,   0,WZ,0,1,    0,    0,0, 3,1));
    tbl.push_back(mk(0,0,WZ,0,1,0,1,   1,WC,0,1,    0,    0,0, 3,1));
    tbl.push_back(mk(0,0,WZ,0,0,0,1,   0,WZ,0,LOOP, !LOOP,0,0, 3,2));
    tbl.push_back(mk(0,0,WZ,0,1,0,0,   LOOP,WA,0,LOOP,!LOOP,0,0,3,2));
    tbl.push_back(mk(0,0,WZ,0,0,1,0,   0,WZ,1,0,    0,    0,0, 0,2));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // fill to capacity, then one more word overflows
    apply(mk(1,0,WZ,0,0,0,0, 0,WZ,1,0,0,0,0, 0,0), "ovf_rst");
    for (int i = 0; i < 20; i++)
      apply(mk(0,1,{23{8'(i)}},0,0,0,0, 0,WZ,(i < 19),0,0,0,0, i+1,0), $sformatf("fill%0d", i));
    apply(mk(0,1,WA,0,0,0,0, 0,WZ,0,0,0,1,0, 20,0), "ovf21");
    apply(mk(0,0,WZ,0,0,1,0, 0,WZ,1,0,0,1,0, 0,0),  "ovf_abort");
    apply(mk(1,0,WZ,0,0,0,0, 0,WZ,1,0,0,0,0, 0,0),  "ovf_clr");

    // stalled serializer: word A held with no advance; trigger and load_valid ignored
    apply(mk(0,1,WA,0,0,0,0, 0,WZ,1,0,0,0,0, 1,0), "st_ldA");
    apply(mk(0,1,WB,0,0,0,0, 0,WZ,1,0,0,0,0, 2,0), "st_ldB");
    apply(mk(0,0,WZ,1,0,0,0, 1,WA,0,1,0,0,0, 2,0), "st_arm");
    for (int j = 0; j < 5; j++)
      apply(mk(0,(j == 3),WC,0,(j == 2),0,0, 1,WA,0,1,0,0,(j >= 2), 2,0), $sformatf("stall%0d", j));
    apply(mk(0,0,WZ,0,0,0,1, 0,WZ,0,1,0,0,1, 2,0), "st_hs");

    // reset while waiting for a trigger clears everything, sticky flags included
    apply(mk(1,0,WZ,0,0,0,0, 0,WZ,1,0,0,0,0, 0,0), "wt_rst");

    // arm with nothing stored is ignored
    apply(mk(0,0,WZ,1,0,0,1, 0,WZ,1,0,0,0,0, 0,0), "arm0");
    apply(mk(0,0,WZ,0,0,0,1, 0,WZ,1,0,0,0,0, 0,0), "arm0_idle");

    // abort beats a coincident arm
    apply(mk(0,1,WA,0,0,0,0, 0,WZ,1,0,0,0,0, 1,0), "ab_ld");
    apply(mk(0,0,WZ,1,0,1,1, 0,WZ,1,0,0,0,0, 0,0), "ab_arm");
    apply(mk(0,0,WZ,0,0,0,1, 0,WZ,1,0,0,0,0, 0,0), "ab_idle");

`ifdef DDS_SWEEP_LOOP_EN
    // two words, five handshakes: A,B,A,B,A
    apply(mk(1,0,WZ,0,0,0,0, 0,WZ,1,0,0,0,0, 0,0), "lp_rst");
    apply(mk(0,1,WA,0,0,0,0, 0,WZ,1,0,0,0,0, 1,0), "lp_ldA");
    apply(mk(0,1,WB,0,0,0,0, 0,WZ,1,0,0,0,0, 2,0), "lp_ldB");
    apply(mk(0,0,WZ,1,0,0,1, 1,WA,0,1,0,0,0, 2,0), "lp_arm");
    for (int k = 0; k < 5; k++) begin
      apply(mk(0,0,WZ,0,0,0,1, 0,WZ,0,1,0,0,0, 2,k % 2), $sformatf("lp_hs%0d", k));
      if (k < 4)
        apply(mk(0,0,WZ,0,1,0,1, 1,((k % 2) == 0) ? WB : WA,0,1,0,0,0, 2,k % 2),
              $sformatf("lp_tr%0d", k));
    end
    chk("loop", "loop_count", WORD_W'(loop_count), WORD_W'(2));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/dds_sweep_scheduler.md
DDS_SWEEP_SCHEDULER -- requirements
Module: dds_sweep_scheduler

Interface
REQ-001 Parameter DEPTH, default 20: number of profile-word slots.
REQ-002 Parameter WORD_W, default 184: profile word width, bit 0 = first bit shifted to DDS.
REQ-003 Parameter CNT_W, default 5: width of slot pointers and counts.
REQ-004 ten_MHz_ext  in  1: sole clock; all logic on rising edge.
REQ-005 rst  in  1: synchronous active-high reset.
REQ-006 load_valid  in  1: a profile word is offered on load_word.
REQ-007 load_word  in  WORD_W [0:WORD_W-1]: profile word from the serial reader.
REQ-008 load_ready  out  1: the scheduler accepts load_word this cycle.
REQ-009 arm  in  1: one-cycle pulse that starts the sweep of the stored words.
REQ-010 trigger  in  1: one-cycle pulse that advances to the next profile.
REQ-011 abort  in  1: one-cycle pulse that returns to IDLE and discards stored words.
REQ-012 dds_valid  out  1: dds_word is presented to the DDS serializer.
REQ-013 dds_word  out  WORD_W: profile word being issued.
REQ-014 dds_ready  in  1: the serializer accepts dds_word.
REQ-015 sweep_total  out  CNT_W: number of stored words.
REQ-016 sweep_index  out  CNT_W: slot of the last accepted or current issue.
REQ-017 busy, done, overflow, missed_trig  out  1 each: status flags.

Function
REQ-018 States: IDLE, ISSUE, WAIT_TRIG, DONE; the state register is encoded explicitly.
REQ-019 IDLE: load_ready=1 while wr_ptr<DEPTH; load_valid&&load_ready writes mem[wr_ptr] and increments wr_ptr; sweep_total=wr_ptr.
REQ-020 Full: wr_ptr==DEPTH forces load_ready=0; load_valid while full sets overflow (sticky) and discards the word.
REQ-021 load_ready=0 in every state except IDLE; load_valid outside IDLE is ignored and does not set overflow.
REQ-022 arm in IDLE with wr_ptr>0 moves to ISSUE with rd_ptr=0; arm with wr_ptr==0 is ignored; arm outside IDLE is ignored.
REQ-023 Latency: arm in cycle k gives dds_valid=1 and dds_word=mem[0] in cycle k+1; dds_word is registered.
REQ-024 ISSUE: dds_valid and dds_word are held stable until dds_ready=1; the handshake completes in the cycle where dds_valid&&dds_ready.
REQ-025 On handshake: sweep_index<=rd_ptr, dds_valid deasserts next cycle; if rd_ptr==wr_ptr-1 go to DONE, else rd_ptr++ and go to WAIT_TRIG.
REQ-026 WAIT_TRIG: trigger moves to ISSUE in the next cycle with dds_word=mem[rd_ptr].
REQ-027 trigger while in ISSUE sets missed_trig (sticky) and is not queued.
REQ-028 trigger in IDLE or DONE is ignored and does not set missed_trig.
REQ-029 DONE: done=1; state holds until abort or rst.
REQ-030 busy=1 in ISSUE and WAIT_TRIG only.
REQ-031 abort in any state: next state IDLE, wr_ptr=0, rd_ptr=0, dds_valid=0, done=0; sticky flags are unchanged.
REQ-032 abort has priority over arm, trigger and load_valid in the same cycle; a handshake coincident with abort counts as completed (the DDS has the word) but has no state effect.
REQ-033 Stored words are never modified outside IDLE writes; pointer arithmetic is CNT_W-bit unsigned, and DEPTH<=2^CNT_W-1 is a design constraint.

Reset
REQ-034 rst gives state=IDLE, wr_ptr=rd_ptr=0, sweep_total=0, sweep_index=0, dds_valid=0, dds_word=0, load_ready=1, busy=0, done=0, overflow=0, missed_trig=0.
REQ-035 rst mid-ISSUE drops dds_valid in the next cycle with no handshake completion; memory contents are don't-care after reset.

Configuration
REQ-036 Macro DDS_SWEEP_LOOP_EN defined: the last-word handshake sets rd_ptr=0 and goes to WAIT_TRIG instead of DONE; an output loop_count (8 bits) increments per wrap, saturates at 255 and is cleared by rst and abort; done is never asserted.
REQ-037 Macro DDS_SWEEP_LOOP_EN undefined: loop_count port is absent and REQ-025/REQ-029 apply as written.

Verification
REQ-038 Load 3 words A,B,C, arm, dds_ready=1 -> A at arm+1; trigger -> B; trigger -> C; then done=1, sweep_index=2, sweep_total=3.
REQ-039 Load 21 words -> load_ready=0 after the 20th; the 21st sets overflow=1; sweep_total=20.
REQ-040 Arm with 2 words, dds_ready low for 5 cycles -> dds_valid and word A stable for 6 cycles, with no advance before the handshake.
REQ-041 Trigger pulsed during ISSUE -> missed_trig=1 and the state stays ISSUE; abort coincident with arm -> IDLE, sweep_total=0.
REQ-042 Arm with 0 words -> no dds_valid and state stays IDLE; rst mid-WAIT_TRIG -> all outputs return to the REQ-034 values next cycle.
REQ-043 With DDS_SWEEP_LOOP_EN and 2 words: 5 handshakes -> word sequence A,B,A,B,A, loop_count=2, done=0.
